fetch_pc_unit: RTL and testbench
================================

# fetch_pc_unit

Instruction-fetch front end of the pipelined ARM core. It holds the program counter and drives `pcPlus4` into input 0 of the 64-bit next-PC `Mux`. It takes the `Mux` output back as `nextPC` and runs a req/ack handshake with instruction memory. It presents one fetched instruction at a time to decode, with stall and flush (branch redirect) support.

## Interface
Parameters:
- `dataWidth`, 64, PC/address width.
- `instWidth`, 32, instruction width.
- `resetPC`, 0, PC value loaded on reset.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `nextPC`  in  dataWidth  next-PC `Mux` output (PC+4 or branch target).
- `pcPlus4`  out  dataWidth  `pc + 4`, to `Mux` input 0.
- `pc`  out  dataWidth  current PC register.
- `imemReq`  out  1  fetch request.
- `imemAddr`  out  dataWidth  fetch address, stable while `imemReq` high.
- `imemAck`  in  1  memory completes request; valid only while `imemReq` high.
- `imemData`  in  instWidth  instruction; sampled when `imemAck`.
- `instr`  out  instWidth  registered instruction to decode.
- `instrPC`  out  dataWidth  PC of `instr`.
- `instrValid`  out  1  `instr` holds an unconsumed instruction.
- `stall`  in  1  decode cannot accept; `instr` is consumed in any cycle with `instrValid && !stall`.
- `flush`  in  1  redirect; `nextPC` carries the target this cycle.

## Operation
- States: FETCH, FULL, DRAIN. `imemReq` = (state is FETCH or DRAIN) && !rst. `imemAddr` = `drainAddr` in DRAIN, else `pc`.
- `pcPlus4` is combinational, `pc + 4` modulo 2^dataWidth; `0xFFFF_FFFF_FFFF_FFFC` wraps to 0. Low PC bits are not checked.
- FETCH:
  - `flush && imemAck`: data discarded, `pc`<=`nextPC`, `instrValid`<=0, stay FETCH.
  - `flush && !imemAck`: `drainAddr`<=`pc`, `pc`<=`nextPC`, `instrValid`<=0, go to DRAIN.
  - `imemAck` without flush: `instr`<=`imemData`, `instrPC`<=`pc`, `instrValid`<=1, `pc`<=`nextPC`, go to FULL.
  - Otherwise hold.
- FULL (no request):
  - `flush`: `instrValid`<=0, `pc`<=`nextPC`, go to FETCH.
  - `!stall`: instruction consumed, `instrValid`<=0, go to FETCH.
  - `stall`: hold all.
- DRAIN (finishes the abandoned request; its address stays stable):
  - `imemAck`: data discarded, go to FETCH.
  - `flush`: `pc`<=`nextPC` (the latest redirect wins), stay DRAIN.
  - Both together: both actions apply.
- `instrValid` is never 1 in FETCH or DRAIN.
- Priority: `rst` > `flush` > `imemAck` > `stall`.

## Timing
- Reset values:
  - `pc`=`resetPC`, state=FETCH.
  - `instrValid`=0, `instr`=0, `instrPC`=0, `drainAddr`=0.
  - `imemReq`=0 during the reset cycle, 1 in the first cycle after.
- Reset mid-transaction drops `imemReq` immediately. Memory must abandon the request and ignore it.
- Latency: with same-cycle ack, `instrValid` rises 1 cycle after `imemReq` rises.
- Throughput: one instruction per 2 cycles at best (FETCH -> FULL -> FETCH).
- `pc` updates on the same edge that captures `instr`. `nextPC` is sampled on that edge.
- `instr`, `instrPC` and `instrValid` are registered with no combinational path from `imemData`. `pcPlus4` depends combinationally on `pc` only.

## Test plan
- Reset with `resetPC`=0x1000, ack returned same cycle as req, `stall`=0, `nextPC`=`pcPlus4` -> `imemAddr` sequence 0x1000, 0x1004, 0x1008. Matching `instrPC` appears with `instrValid` high every second cycle.
- Ack 3 cycles after req, then `stall` high 4 cycles -> `imemAddr` stable during wait. `instr`/`instrValid` hold through stall, `imemReq`=0 in FULL, next req the cycle after `stall` falls.
- `flush` in FETCH without ack, `nextPC`=0x2000 -> DRAIN holds `imemAddr` at old address until ack. That data is dropped (`instrValid` stays 0), then req at 0x2000.
- `flush` coincident with `imemAck` -> no `instrValid`. Next req at the flush target. Also: `flush` in FULL with `stall`=1 -> `instrValid` drops next cycle.
- `resetPC`=0xFFFF_FFFF_FFFF_FFFC -> `pcPlus4`=0. Second fetch address is 0.
- `rst` asserted in DRAIN -> next cycle `imemReq`=0, `pc`=`resetPC`, `instrValid`=0. Normal fetch resumes after `rst` falls.

Source files
------------

// File: rtl/fetch_pc_unit_if.sv
`default_nettype none
// ============================================================================
// fetch_pc_unit_if : instruction-memory req/ack fetch bus
// Rev 1.0
// ============================================================================
interface fetch_pc_unit_if #(
  parameter int dataWidth = 64,
  parameter int instWidth = 32
);
  logic                 imemReq;
  logic [dataWidth-1:0] imemAddr;
  logic                 imemAck;
  logic [instWidth-1:0] imemData;

  modport master (
    output imemReq,
    output imemAddr,
    input  imemAck,
    input  imemData
  );

  modport slave (
    input  imemReq,
    input  imemAddr,
    output imemAck,
    output imemData
  );
endinterface
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// fetch_pc_unit : PC register, imem req/ack fetch and single-entry decode slot
// Rev 1.0
// ============================================================================
module fetch_pc_unit #(
  parameter int                   dataWidth = 64,
  parameter int                   instWidth = 32,
  parameter logic [dataWidth-1:0] resetPC   = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [dataWidth-1:0] nextPC,
  output logic [dataWidth-1:0] pcPlus4,
  output logic [dataWidth-1:0] pc,
  output logic [instWidth-1:0] instr,
  output logic [dataWidth-1:0] instrPC,
  output logic                 instrValid,
  input  logic                 stall,
  input  logic                 flush,
  fetch_pc_unit_if.master      imem
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] FULL  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]           state_q,      state_d;
  logic [dataWidth-1:0] pc_q,         pc_d;
  logic [dataWidth-1:0] drainAddr_q,  drainAddr_d;
  logic [instWidth-1:0] instr_q,      instr_d;
  logic [dataWidth-1:0] instrPC_q,    instrPC_d;
  logic                 instrValid_q, instrValid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= resetPC;
      drainAddr_q  <= '0;
      instr_q      <= '0;
      instrPC_q    <= '0;
      instrValid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drainAddr_q  <= drainAddr_d;
      instr_q      <= instr_d;
      instrPC_q    <= instrPC_d;
      instrValid_q <= instrValid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drainAddr_d  = drainAddr_q;
    instr_d      = instr_q;
    instrPC_d    = instrPC_q;
    instrValid_d = instrValid_q;
    case (state_q)
      FETCH: begin
        if (flush) begin
          pc_d         = nextPC;
          instrValid_d = 1'b0;
          // An unanswered request must still be completed before redirecting.
          if (!imem.imemAck) begin
            drainAddr_d = pc_q;
            state_d     = DRAIN;
          end
        end else if (imem.imemAck) begin
          instr_d      = imem.imemData;
          instrPC_d    = pc_q;
          instrValid_d = 1'b1;
          pc_d         = nextPC;
          state_d      = FULL;
        end
      end
      FULL: begin
        if (flush) begin
          instrValid_d = 1'b0;
          pc_d         = nextPC;
          state_d      = FETCH;
        end else if (!stall) begin
          instrValid_d = 1'b0;
          state_d      = FETCH;
        end
      end
      DRAIN: begin
        if (flush) pc_d = nextPC;
        if (imem.imemAck) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    imem.imemReq  = ((state_q == FETCH) || (state_q == DRAIN)) && !rst;
    imem.imemAddr = (state_q == DRAIN) ? drainAddr_q : pc_q;
    pcPlus4       = pc_q + dataWidth'(4);
  end

  assign pc         = pc_q;
  assign instr      = instr_q;
  assign instrPC    = instrPC_q;
  assign instrValid = instrValid_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_pc_unit : directed vector bench for fetch_pc_unit
// Rev 1.0
// ============================================================================
module tb_fetch_pc_unit;

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] data;
    logic        stall;
    logic        flush;
    logic [63:0] tgt;
    logic        req;
    logic [63:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [63:0] ipc;
    logic [63:0] pc;
  } vec_t;

  localparam int NV = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int   nvec = 0;
  int   nerr = 0;
  vec_t vecs [NV];

  // Main DUT, resetPC = 0x1000
  logic        rst, stall, flush, ack;
  logic [31:0] data;
  logic [63:0] tgt;
  logic [63:0] nextPC, pcPlus4, pc, instrPC;
  logic [31:0] instr;
  logic        instrValid;

  fetch_pc_unit_if #(.dataWidth(64), .instWidth(32)) imem ();
  assign imem.imemAck  = ack;
  assign imem.imemData = data;
  assign nextPC        = flush ? tgt : pcPlus4;

  fetch_pc_unit #(.dataWidth(64), .instWidth(32), .resetPC(64'h1000)) dut (
    .clk(clk), .rst(rst), .nextPC(nextPC), .pcPlus4(pcPlus4), .pc(pc),
    .instr(instr), .instrPC(instrPC), .instrValid(instrValid),
    .stall(stall), .flush(flush), .imem(imem.master)
  );

  // Wrap DUT, resetPC = top of address space
  logic        rst2, ack2;
  logic [63:0] nextPC2, pcPlus4_2, pc2, instrPC2;
  logic [31:0] instr2;
  logic        instrValid2;

  fetch_pc_unit_if #(.dataWidth(64), .instWidth(32)) imem2 ();
  assign imem2.imemAck  = ack2;
  assign imem2.imemData = 32'hE0000001;
  assign nextPC2        = pcPlus4_2;

  fetch_pc_unit #(.dataWidth(64), .instWidth(32),
                  .resetPC(64'hFFFF_FFFF_FFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst2), .nextPC(nextPC2), .pcPlus4(pcPlus4_2), .pc(pc2),
    .instr(instr2), .instrPC(instrPC2), .instrValid(instrValid2),
    .stall(1'b0), .flush(1'b0), .imem(imem2.master)
  );

  function automatic vec_t V(logic r, logic a, logic [31:0] d, logic s, logic f,
                             logic [63:0] t, logic eq, logic [63:0] ea, logic ev,
                             logic [31:0] ei, logic [63:0] eipc, logic [63:0] epc);
    vec_t v;
    v.rst = r; v.ack = a; v.data = d; v.stall = s; v.flush = f; v.tgt = t;
    v.req = eq; v.addr = ea; v.valid = ev; v.instr = ei; v.ipc = eipc; v.pc = epc;
    return v;
  endfunction

  task automatic check2(string name, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    //            rst ack data          stl fls tgt       req addr     vld instr         iPC      pc
    vecs[0]  = V(0, 1, 32'hA0000001, 0, 0, 64'h0,    1, 64'h1000, 0, 32'h0,        64'h0,    64'h1000);
    vecs[1]  = V(0, 0, 32'h0,        0, 0, 64'h0,    0, 64'h1004, 1, 32'hA0000001, 64'h1000, 64'h1004);
    vecs[2]  = V(0, 1, 32'hA0000002, 0, 0, 64'h0,    1, 64'h1004, 0, 32'hA0000001, 64'h1000, 64'h1004);
    vecs[3]  = V(0, 0, 32'h0,        0, 0, 64'h0,    0, 64'h1008, 1, 32'hA0000002, 64'h1004, 64'h1008);
    vecs[4]  = V(0, 1, 32'hA0000003, 0, 0, 64'h0,    1, 64'h1008, 0, 32'hA0000002, 64'h1004, 64'h1008);
    vecs[5]  = V(0, 0, 32'h0,        0, 0, 64'h0,    0, 64'h100C, 1, 32'hA0000003, 64'h1008, 64'h100C);
    // late ack, then stall held four cycles
    vecs[6]  = V(0, 0, 32'h0,        0, 0, 64'h0,    1, 64'h100C, 0, 32'hA0000003, 64'h1008, 64'h100C);
    vecs[7]  = V(0, 0, 32'h0,        0, 0, 64'h0,    1, 64'h100C, 0, 32'hA0000003, 64'h1008, 64'h100C);
    vecs[8]  = V(0, 0, 32'h0,        0, 0, 64'h0,    1, 64'h100C, 0, 32'hA0000003, 64'h1008, 64'h100C);
    vecs[9]  = V(0, 1, 32'hB0000001, 1, 0, 64'h0,    1, 64'h100C, 0, 32'hA0000003, 64'h1008, 64'h100C);
    vecs[10] = V(0, 0, 32'h0,        1, 0, 64'h0,    0, 64'h1010, 1, 32'hB0000001, 64'h100C, 64'h1010);
    vecs[11] = V(0, 0, 32'h0,        1, 0, 64'h0,    0, 64'h1010, 1, 32'hB0000001, 64'h100C, 64'h1010);
    vecs[12] = V(0, 0, 32'h0,        1, 0, 64'h0,    0, 64'h1010, 1, 32'hB0000001, 64'h100C, 64'h1010);
    vecs[13] = V(0, 0, 32'h0,        1, 0, 64'h0,    0, 64'h1010, 1, 32'hB0000001, 64'h100C, 64'h1010);
    vecs[14] = V(0, 0, 32'h0,        0, 0, 64'h0,    0, 64'h1010, 1, 32'hB0000001, 64'h100C, 64'h1010);
    vecs[15] = V(0, 0, 32'h0,        0, 0, 64'h0,    1, 64'h1010, 0, 32'hB0000001, 64'h100C, 64'h1010);
    // flush without ack: drain old address, drop its data
    vecs[16] = V(0, 0, 32'h0,        0, 1, 64'h2000, 1, 64'h1010, 0, 32'hB0000001, 64'h100C, 64'h1010);
    vecs[17] = V(0, 0, 32'h0,        0, 0, 64'h0,    1, 64'h1010, 0, 32'hB0000001, 64'h100C, 64'h2000);
    vecs[18] = V(0, 1, 32'hDEADBEEF, 0, 0, 64'h0,    1, 64'h1010, 0, 32'hB0000001, 64'h100C, 64'h2000);
    vecs[19] = V(0, 0, 32'h0,        0, 0, 64'h0,    1, 64'h2000, 0, 32'hB0000001, 64'h100C, 64'h2000);
    // flush with ack, then flush in FULL under stall
    vecs[20] = V(0, 1, 32'hC0000001, 0, 1, 64'h3000, 1, 64'h2000, 0, 32'hB0000001, 64'h100C, 64'h2000);
    vecs[21] = V(0, 1, 32'hC0000002, 0, 0, 64'h0,    1, 64'h3000, 0, 32'hB0000001, 64'h100C, 64'h3000);
    vecs[22] = V(0, 0, 32'h0,        1, 1, 64'h4000, 0, 64'h3004, 1, 32'hC0000002, 64'h3000, 64'h3004);
    vecs[23] = V(0, 0, 32'h0,        0, 0, 64'h0,    1, 64'h4000, 0, 32'hC0000002, 64'h3000, 64'h4000);
    // repeated flushes in DRAIN: latest target wins, ack+flush together
    vecs[24] = V(0, 0, 32'h0,        0, 1, 64'h5000, 1, 64'h4000, 0, 32'hC0000002, 64'h3000, 64'h4000);
    vecs[25] = V(0, 0, 32'h0,        0, 1, 64'h6000, 1, 64'h4000, 0, 32'hC0000002, 64'h3000, 64'h5000);
    vecs[26] = V(0, 1, 32'hDEAD0002, 0, 1, 64'h7000, 1, 64'h4000, 0, 32'hC0000002, 64'h3000, 64'h6000);
    vecs[27] = V(0, 0, 32'h0,        0, 0, 64'h0,    1, 64'h7000, 0, 32'hC0000002, 64'h3000, 64'h7000);
    // reset while draining
    vecs[28] = V(0, 0, 32'h0,        0, 1, 64'h8000, 1, 64'h7000, 0, 32'hC0000002, 64'h3000, 64'h7000);
    vecs[29] = V(1, 0, 32'h0,        0, 0, 64'h0,    0, 64'h7000, 0, 32'hC0000002, 64'h3000, 64'h8000);
    vecs[30] = V(0, 1, 32'hD0000001, 0, 0, 64'h0,    1, 64'h1000, 0, 32'h0,        64'h0,    64'h1000);
    vecs[31] = V(0, 0, 32'h0,        0, 0, 64'h0,    0, 64'h1004, 1, 32'hD0000001, 64'h1000, 64'h1004);

    rst = 1'b1; ack = 1'b0; data = '0; stall = 1'b0; flush = 1'b0; tgt = '0;
    rst2 = 1'b1; ack2 = 1'b0;
    @(negedge clk);
    check2("reset_req", {63'h0, imem.imemReq}, 64'h0);
    check2("reset_req_wrap", {63'h0, imem2.imemReq}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      rst = vecs[i].rst; ack = vecs[i].ack; data = vecs[i].data;
      stall = vecs[i].stall; flush = vecs[i].flush; tgt = vecs[i].tgt;
      @(negedge clk);
      nvec++;
      if (imem.imemReq !== vecs[i].req || imem.imemAddr !== vecs[i].addr ||
          instrValid !== vecs[i].valid || instr !== vecs[i].instr ||
          instrPC !== vecs[i].ipc || pc !== vecs[i].pc || pcPlus4 !== vecs[i].pc + 64'd4) begin
        nerr++;
        $display("FAIL vec%0d: got req=%b addr=%h vld=%b instr=%h ipc=%h pc=%h p4=%h expected req=%b addr=%h vld=%b instr=%h ipc=%h pc=%h",
                 i, imem.imemReq, imem.imemAddr, instrValid, instr, instrPC, pc, pcPlus4,
                 vecs[i].req, vecs[i].addr, vecs[i].valid, vecs[i].instr, vecs[i].ipc, vecs[i].pc);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0; ack = 1'b0; flush = 1'b0; stall = 1'b0;

    // PC wrap at the top of the address space
    rst2 = 1'b1;
    @(posedge clk); #1;
    rst2 = 1'b0; ack2 = 1'b1;
    @(negedge clk);
    check2("wrap_pcPlus4", pcPlus4_2, 64'h0);
    check2("wrap_addr0", imem2.imemAddr, 64'hFFFF_FFFF_FFFF_FFFC);
    check2("wrap_req0", {63'h0, imem2.imemReq}, 64'h1);
    @(posedge clk); #1;
    ack2 = 1'b0;
    @(negedge clk);
    check2("wrap_valid", {63'h0, instrValid2}, 64'h1);
    check2("wrap_instrPC", instrPC2, 64'hFFFF_FFFF_FFFF_FFFC);
    check2("wrap_instr", {32'h0, instr2}, 64'hE0000001);
    check2("wrap_pc", pc2, 64'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check2("wrap_req1", {63'h0, imem2.imemReq}, 64'h1);
    check2("wrap_addr1", imem2.imemAddr, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
